// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: CPU, camera and RAM signals of the data-memory arbiter
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic cpu_re;
  logic cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic cpu_stall;
  logic cam_valid;
  logic cam_ready;
  logic [ADDR_W-1:0] cam_addr;
  logic [DATA_W-1:0] cam_data;
  logic mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [CW-1:0] fifo_count;
  logic drain_active;
  modport master (
    output cpu_re, cpu_we, cpu_addr, cpu_wdata, cam_valid, cam_addr, cam_data, mem_rdata,
    input cpu_rdata, cpu_stall, cam_ready, mem_we, mem_addr, mem_wdata, fifo_count, drain_active
  );
  modport slave (
    input cpu_re, cpu_we, cpu_addr, cpu_wdata, cam_valid, cam_addr, cam_data, mem_rdata,
    output cpu_rdata, cpu_stall, cam_ready, mem_we, mem_addr, mem_wdata, fifo_count, drain_active
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data RAM between the CPU memory stage and a buffered camera writer
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic clock,
  input logic reset,
  dmem_arbiter_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [0:0] NORMAL = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  logic [0:0] state;
  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve;
  logic [ADDR_W-1:0] last_addr;
  logic [DATA_W-1:0] last_wdata;
  logic rd_pending;
  logic cpu_req;
  logic nonempty;
  logic full;
  logic push;
  logic cam_grant;
  logic cpu_grant;
  logic to_drain;
  logic to_normal;
  // arbitration: CPU wins in NORMAL, camera owns the RAM in DRAIN; everything is gated off in reset
  always_comb begin
    cpu_req = bus.cpu_re | bus.cpu_we;
    nonempty = count != '0;
    full = count == CW'(FIFO_DEPTH);
    bus.cam_ready = reset && !full;
    push = bus.cam_valid && bus.cam_ready;
    cam_grant = reset && nonempty && (state == DRAIN || !cpu_req);
    cpu_grant = reset && state == NORMAL && cpu_req;
    bus.cpu_stall = reset && state == DRAIN && cpu_req;
    bus.mem_we = cam_grant || (cpu_grant && bus.cpu_we);
    bus.mem_addr = cam_grant ? fifo_addr[rd_ptr] : cpu_grant ? bus.cpu_addr : last_addr;
    bus.mem_wdata = cam_grant ? fifo_data[rd_ptr] : cpu_grant ? bus.cpu_wdata : last_wdata;
    to_drain = full || (starve >= SW'(STARVE_LIMIT - 1) && !cam_grant);
    to_normal = (count - CW'(1)) <= CW'(FIFO_DEPTH / 2) && !push;
    bus.fifo_count = count;
    bus.drain_active = state == DRAIN;
  end
  // FIFO payload storage, written at the tail; contents need no reset
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_addr[wr_ptr] <= bus.cam_addr;
      fifo_data[wr_ptr] <= bus.cam_data;
    end
  end
  // occupancy, pointers, mode, starvation counter and the idle-cycle address hold
  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      state <= NORMAL;
      starve <= '0;
      last_addr <= '0;
      last_wdata <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(cam_grant);
      count <= count + CW'(push) - CW'(cam_grant);
      state <= state == NORMAL ? (to_drain ? DRAIN : NORMAL) : (to_normal ? NORMAL : DRAIN);
      starve <= (!nonempty || cam_grant) ? '0 : starve == SW'(STARVE_LIMIT) ? starve : starve + SW'(1);
      last_addr <= bus.mem_addr;
      last_wdata <= bus.mem_wdata;
    end
  end
  // read return: RAM data arrives the cycle after a granted read and is captured then
  always_ff @(posedge clock) begin
    if (!reset) begin
      rd_pending <= 1'b0;
      bus.cpu_rdata <= '0;
    end else begin
      rd_pending <= cpu_grant && bus.cpu_re;
      if (rd_pending) bus.cpu_rdata <= bus.mem_rdata;
    end
  end
endmodule
